// File: rtl/timer_counter_prs.sv
// Timer count register with prescaler, debug halt handshake and compare-match interrupt.
// Optional sticky overflow flag is enabled by defining TIMER_CNT_OVF_EN.
module timer_counter_prs #(
  parameter int                 CNT_W       = 64,
  parameter int                 DIV_W       = 4,
  parameter logic [CNT_W-1:0]   CNT_DEFAULT = '0,
  localparam int                NWORD       = CNT_W / 32,
  localparam int                SEL_W       = (NWORD > 1) ? $clog2(NWORD) : 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               cnt_en,
  input  logic               cnt_clr,
  input  logic               div_en,
  input  logic [DIV_W-1:0]   div_val,
  input  logic               halt_req,
  output logic               halt_ack,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_word,
  input  logic [3:0]         pstrb,
  input  logic [31:0]        wdt,
  input  logic [CNT_W-1:0]   cmp_val,
  output logic [CNT_W-1:0]   cnt,
  output logic               cmp_match,
  output logic               cmp_int
`ifdef TIMER_CNT_OVF_EN
  ,
  output logic               ovf_flag,
  input  logic               ovf_clr
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             halt_ack_q, halt_ack_d;
  logic             cmp_match_q, cmp_match_d;
  logic             cmp_int_q, cmp_int_d;
  logic             armed_q;
  logic             run;
  logic             div_hit;
  logic             tick;
  logic [NWORD-1:0] wr_hit;
  logic             wr_any;
  logic             cnt_eq;

  // armed_q holds off counting for the first edge after reset release
  assign run     = cnt_en & ~halt_ack_q & armed_q;
  assign div_hit = (div_cnt_q >= div_val);
  assign tick    = run & (~div_en | div_hit);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_eq  = (cnt_q == cmp_val);

  // Out-of-range word indices never match any w, so such writes are dropped
  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NWORD; w++) begin
      wr_hit[w] = wr_en & (wr_word == SEL_W'(w));
    end
  end

  assign wr_any = |wr_hit;

  always_comb begin
    cnt_d = cnt_q;
    for (int w = 0; w < NWORD; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_hit[w] && pstrb[b]) begin
          cnt_d[w*32 + b*8 +: 8] = wdt[b*8 +: 8];
        end else if (cnt_clr) begin
          cnt_d[w*32 + b*8 +: 8] = CNT_DEFAULT[w*32 + b*8 +: 8];
        end else if (tick) begin
          cnt_d[w*32 + b*8 +: 8] = cnt_inc[w*32 + b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (wr_any || cnt_clr) begin
      div_cnt_d = '0;
    end else if (div_en && run) begin
      div_cnt_d = div_hit ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  assign halt_ack_d  = halt_req & cnt_en;
  assign cmp_match_d = cnt_eq;
  assign cmp_int_d   = cnt_eq & ~cmp_match_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= CNT_DEFAULT;
      div_cnt_q   <= '0;
      halt_ack_q  <= 1'b0;
      cmp_match_q <= 1'b0;
      cmp_int_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_cnt_q   <= div_cnt_d;
      halt_ack_q  <= halt_ack_d;
      cmp_match_q <= cmp_match_d;
      cmp_int_q   <= cmp_int_d;
      armed_q     <= 1'b1;
    end
  end

  assign cnt       = cnt_q;
  assign halt_ack  = halt_ack_q;
  assign cmp_match = cmp_match_q;
  assign cmp_int   = cmp_int_q;

`ifdef TIMER_CNT_OVF_EN
  logic ovf_q, ovf_d;
  logic wrap;

  // Only a genuine count wrap sets the flag, not a load that happens to land on zero
  assign wrap = tick & (&cnt_q) & ~cnt_clr & ~wr_any;

  always_comb begin
    ovf_d = ovf_q;
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_flag = ovf_q;
`endif

endmodule

// File: tb/tb_timer_counter_prs.sv
// Self-checking bench for timer_counter_prs: directed scenarios plus randomized run
// against a behavioural model.
module tb_timer_counter_prs;
  localparam int CNT_W = 64;
  localparam int DIV_W = 4;
  localparam logic [CNT_W-1:0] CNT_DEFAULT = '0;
  localparam int NWORD = CNT_W / 32;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              cnt_en, cnt_clr, div_en, halt_req, halt_ack;
  logic [DIV_W-1:0]  div_val;
  logic              wr_en;
  logic [0:0]        wr_word;
  logic [3:0]        pstrb;
  logic [31:0]       wdt;
  logic [CNT_W-1:0]  cmp_val, cnt;
  logic              cmp_match, cmp_int;
`ifdef TIMER_CNT_OVF_EN
  logic              ovf_flag, ovf_clr;
`endif

  int vectors = 0;
  int errors  = 0;

  // model state
  logic [CNT_W-1:0] m_cnt;
  int               m_div;
  logic             m_halt, m_match, m_int, m_armed, m_ovf;

  timer_counter_prs #(.CNT_W(CNT_W), .DIV_W(DIV_W), .CNT_DEFAULT(CNT_DEFAULT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .div_en(div_en), .div_val(div_val), .halt_req(halt_req), .halt_ack(halt_ack),
    .wr_en(wr_en), .wr_word(wr_word), .pstrb(pstrb), .wdt(wdt), .cmp_val(cmp_val),
    .cnt(cnt), .cmp_match(cmp_match), .cmp_int(cmp_int)
`ifdef TIMER_CNT_OVF_EN
    , .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_cnt = CNT_DEFAULT; m_div = 0; m_halt = 0; m_match = 0; m_int = 0; m_armed = 0; m_ovf = 0;
  endtask

  // Advance one clock: model computes next state from the pre-edge inputs,
  // DUT outputs are then sampled 1 time unit after the edge.
  task automatic step();
    logic [CNT_W-1:0] nxt;
    logic run, tick, wr_ok, eq, ovf_clr_v;
    int ndiv;
    run   = cnt_en && !m_halt && m_armed;
    tick  = run && (!div_en || m_div >= int'(div_val));
    wr_ok = wr_en && (int'(wr_word) < NWORD);
    nxt   = tick ? m_cnt + 1 : m_cnt;
    if (cnt_clr) nxt = CNT_DEFAULT;
    if (wr_ok)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) nxt[int'(wr_word)*32 + b*8 +: 8] = wdt[b*8 +: 8];
    ndiv = m_div;
    if (wr_ok || cnt_clr) ndiv = 0;
    else if (div_en && run) ndiv = (m_div >= int'(div_val)) ? 0 : m_div + 1;
    eq = (m_cnt == cmp_val);
`ifdef TIMER_CNT_OVF_EN
    ovf_clr_v = ovf_clr;
`else
    ovf_clr_v = 1'b0;
`endif
    if (tick && m_cnt == '1 && !cnt_clr && !wr_ok) m_ovf = 1'b1;
    else if (ovf_clr_v) m_ovf = 1'b0;
    m_int   = eq && !m_match;
    m_match = eq;
    m_halt  = halt_req && cnt_en;
    m_armed = 1'b1;
    m_cnt   = nxt;
    m_div   = ndiv;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cnt_en = 0; cnt_clr = 0; div_en = 0; div_val = '0; halt_req = 0;
    wr_en = 0; wr_word = '0; pstrb = '0; wdt = '0;
`ifdef TIMER_CNT_OVF_EN
    ovf_clr = 0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    cmp_val = 64'hFFFF;
    sys_rst_n = 0;
    model_reset();
    #12;
    vectors++;
    if ({cnt, halt_ack, cmp_match, cmp_int} !== {CNT_DEFAULT, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got cnt=%h ack=%b match=%b int=%b, want cnt=%h 0 0 0",
               cnt, halt_ack, cmp_match, cmp_int, CNT_DEFAULT);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1;
    step();
    cnt_en = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      vectors++;
      if ({cnt, halt_ack, cmp_match, cmp_int} !== {64'(i), 3'b000}) begin
        errors++;
        $display("FAIL free_run cycle %0d got cnt=%h ack=%b match=%b int=%b, want cnt=%h 0 0 0",
                 i, cnt, halt_ack, cmp_match, cmp_int, 64'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    cnt_en = 1;
    repeat (7) step();
    #1 sys_rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if (cnt !== CNT_DEFAULT) begin
      errors++;
      $display("FAIL async_reset got cnt=%h want %h", cnt, CNT_DEFAULT);
    end
    sys_rst_n = 1;
    step();
    vectors++;
    if (cnt !== CNT_DEFAULT) begin
      errors++;
      $display("FAIL first_edge_after_reset got cnt=%h want %h", cnt, CNT_DEFAULT);
    end
    step();
    vectors++;
    if (cnt !== CNT_DEFAULT + 1) begin
      errors++;
      $display("FAIL second_edge_after_reset got cnt=%h want %h", cnt, CNT_DEFAULT + 1);
    end
  endtask

  task automatic test_byte_write();
    idle_inputs();
    wr_en = 1; wr_word = 0; pstrb = 4'hF; wdt = 32'hFF; step();
    wr_word = 1; wdt = 32'h0; step();
    vectors++;
    if (cnt !== 64'hFF) begin
      errors++;
      $display("FAIL byte_write_load got cnt=%h want %h", cnt, 64'hFF);
    end
    cnt_en = 1; wr_word = 0; pstrb = 4'b0010; wdt = 32'h0000_AB00; step();
    vectors++;
    if (cnt !== 64'hAB00 || cnt !== m_cnt) begin
      errors++;
      $display("FAIL byte_write_with_tick got cnt=%h want %h", cnt, 64'hAB00);
    end
    cnt_en = 0; wr_word = 1; pstrb = 4'hF; wdt = 32'h1234_5678; step();
    wr_en = 0;
    vectors++;
    if (cnt !== 64'h1234_5678_0000_AB00) begin
      errors++;
      $display("FAIL word1_write got cnt=%h want %h", cnt, 64'h1234_5678_0000_AB00);
    end
  endtask

  task automatic test_prescaler();
    idle_inputs();
    cnt_clr = 1; step(); cnt_clr = 0;
    div_en = 1; div_val = 3; cnt_en = 1;
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if (cnt !== 64'(i / 4)) begin
        errors++;
        $display("FAIL prescaler cycle %0d got cnt=%h want %h", i, cnt, 64'(i / 4));
      end
    end
    step(); step();
    div_val = 1;
    step();
    vectors++;
    if (cnt !== 64'd4) begin
      errors++;
      $display("FAIL prescaler_lowered got cnt=%h want %h", cnt, 64'd4);
    end
  endtask

  task automatic test_halt();
    idle_inputs();
    cnt_clr = 1; step(); cnt_clr = 0;
    cnt_en = 1;
    repeat (5) step();
    halt_req = 1;
    step();
    vectors++;
    if ({cnt, halt_ack} !== {64'd6, 1'b1}) begin
      errors++;
      $display("FAIL halt_enter got cnt=%h ack=%b want cnt=6 ack=1", cnt, halt_ack);
    end
    repeat (3) begin
      step();
      vectors++;
      if ({cnt, halt_ack} !== {64'd6, 1'b1}) begin
        errors++;
        $display("FAIL halt_frozen got cnt=%h ack=%b want cnt=6 ack=1", cnt, halt_ack);
      end
    end
    wr_en = 1; wr_word = 0; pstrb = 4'hF; wdt = 32'h20; step(); wr_en = 0;
    vectors++;
    if (cnt !== 64'h20) begin
      errors++;
      $display("FAIL halt_write got cnt=%h want 20", cnt);
    end
    halt_req = 0;
    step();
    vectors++;
    if ({cnt, halt_ack} !== {64'h20, 1'b0}) begin
      errors++;
      $display("FAIL halt_release got cnt=%h ack=%b want cnt=20 ack=0", cnt, halt_ack);
    end
    step();
    vectors++;
    if (cnt !== 64'h21) begin
      errors++;
      $display("FAIL halt_resume got cnt=%h want 21", cnt);
    end
  endtask

  task automatic test_compare_wrap();
    int pulses;
    idle_inputs();
    cmp_val = 64'h10;
    cnt_clr = 1; step(); cnt_clr = 0;
    cnt_en = 1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cmp_int) pulses++;
      vectors++;
      if ({cmp_match, cmp_int} !== {m_match, m_int}) begin
        errors++;
        $display("FAIL compare cnt=%h got match=%b int=%b want %b %b",
                 cnt, cmp_match, cmp_int, m_match, m_int);
      end
      if (cnt == 64'h11) begin
        vectors++;
        if ({cmp_match, cmp_int} !== 2'b11) begin
          errors++;
          $display("FAIL compare_hit got match=%b int=%b want 1 1", cmp_match, cmp_int);
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL compare_pulse_count got %0d want 1", pulses);
    end
    cnt_en = 0;
    wr_en = 1; wr_word = 0; pstrb = 4'hF; wdt = 32'h10;
    wr_word = 1; wdt = 32'h0; step();
    wr_word = 0; wdt = 32'h10; step(); wr_en = 0;
    step();
    vectors++;
    if ({cmp_match, cmp_int} !== 2'b11) begin
      errors++;
      $display("FAIL compare_after_write got match=%b int=%b want 1 1", cmp_match, cmp_int);
    end
    cmp_val = 64'h5555;
    wr_en = 1; pstrb = 4'hF; wdt = 32'hFFFF_FFFF;
    wr_word = 0; step();
    wr_word = 1; step(); wr_en = 0;
    cnt_en = 1; step(); cnt_en = 0;
    vectors++;
    if (cnt !== 64'h0) begin
      errors++;
      $display("FAIL wrap got cnt=%h want 0", cnt);
    end
`ifdef TIMER_CNT_OVF_EN
    step();
    vectors++;
    if (ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b want 1", ovf_flag);
    end
    ovf_clr = 1; step(); ovf_clr = 0;
    vectors++;
    if (ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", ovf_flag);
    end
`endif
  endtask

  task automatic test_clear_priority();
    idle_inputs();
    wr_en = 1; wr_word = 1; pstrb = 4'hF; wdt = 32'hDEAD_BEEF; step(); wr_en = 0;
    cnt_en = 1; div_en = 1; div_val = 5;
    repeat (8) step();
    cnt_clr = 1; wr_en = 1; wr_word = 0; pstrb = 4'b0001; wdt = 32'hAA;
    step();
    cnt_clr = 0; wr_en = 0;
    vectors++;
    if (cnt !== 64'hAA) begin
      errors++;
      $display("FAIL clear_vs_write got cnt=%h want aa", cnt);
    end
    repeat (5) step();
    vectors++;
    if (cnt !== 64'hAA) begin
      errors++;
      $display("FAIL clear_div_reset_hold got cnt=%h want aa", cnt);
    end
    step();
    vectors++;
    if (cnt !== 64'hAB) begin
      errors++;
      $display("FAIL clear_div_reset_tick got cnt=%h want ab", cnt);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 2000; i++) begin
      cnt_en   = ($urandom_range(0, 9) < 8);
      cnt_clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) div_en = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) div_val = DIV_W'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
      wr_en    = ($urandom_range(0, 19) == 0);
      wr_word  = 1'($urandom_range(0, 1));
      pstrb    = 4'($urandom);
      wdt      = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 29) == 0) cmp_val = m_cnt + 64'($urandom_range(0, 6));
`ifdef TIMER_CNT_OVF_EN
      ovf_clr = ($urandom_range(0, 9) == 0);
`endif
      step();
      vectors++;
      if ({cnt, halt_ack, cmp_match, cmp_int} !== {m_cnt, m_halt, m_match, m_int}) begin
        errors++;
        $display("FAIL random cycle %0d got cnt=%h ack=%b match=%b int=%b want cnt=%h ack=%b match=%b int=%b",
                 i, cnt, halt_ack, cmp_match, cmp_int, m_cnt, m_halt, m_match, m_int);
      end
`ifdef TIMER_CNT_OVF_EN
      vectors++;
      if (ovf_flag !== m_ovf) begin
        errors++;
        $display("FAIL random_ovf cycle %0d got %b want %b", i, ovf_flag, m_ovf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_byte_write();
    test_prescaler();
    test_halt();
    test_compare_wrap();
    test_clear_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter_prs.md
Name: timer_counter_prs

Overview:
- Parametrised next-generation timer count register.
- Holds a CNT_W-bit up-counter and exposes it to the APB register file as 32-bit words with byte-strobe writes.
- Adds a programmable prescaler, a debug halt handshake, and a compare-match output with interrupt pulse.
- Sits between the APB register decode (supplies write select, strobes, data, control bits) and the interrupt logic.

Parameters:
- CNT_W, 64, counter width in bits; must be a multiple of 32, legal range 32..128.
- DIV_W, 4, width of the prescaler divide field.
- CNT_DEFAULT, 0, reset and clear value of the counter.
- NWORD (localparam), CNT_W/32, number of 32-bit words.
- SEL_W (localparam), max(1, clog2(NWORD)), width of the word index.

Ports:
- sys_clk  in  1  clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- cnt_en  in  1  count enable.
- cnt_clr  in  1  synchronous clear of counter and prescaler.
- div_en  in  1  prescaler enable.
- div_val  in  DIV_W  prescaler terminal value; tick period is div_val+1 cycles.
- halt_req  in  1  debug halt request (level).
- halt_ack  out  1  registered acknowledge; counting is frozen.
- wr_en  in  1  register write strobe (APB access phase, pwrite & psel & penable decoded).
- wr_word  in  SEL_W  index of the 32-bit word written; 0 is the least significant word.
- pstrb  in  4  byte strobes.
- wdt  in  32  write data.
- cmp_val  in  CNT_W  compare value from the register file.
- cnt  out  CNT_W  current count, equal to the register outputs.
- cmp_match  out  1  registered level; high while cnt == cmp_val.
- cmp_int  out  1  one-cycle pulse on the rising edge of cmp_match.

Behaviour:
- Reset (async, sys_rst_n=0): cnt=CNT_DEFAULT, prescaler count=0, halt_ack=0, cmp_match=0, cmp_int=0.
- Tick generation:
  - div_en=0: tick=cnt_en & ~halt_ack on every cycle.
  - div_en=1: an internal DIV_W-bit div_cnt increments each cycle while cnt_en & ~halt_ack.
  - When div_cnt >= div_val, tick=1 and div_cnt returns to 0 on the next edge.
  - The >= comparison handles div_val being lowered mid-run. div_val=0 gives a tick every cycle.
- Per-byte priority, evaluated independently for every byte b of every word w:
  - 1: wr_en & wr_word==w & pstrb[b] loads wdt byte.
  - 2: cnt_clr loads the CNT_DEFAULT byte.
  - 3: tick loads byte of (cnt+1).
  - 4: hold.
- The incremented value is computed on the full CNT_W vector from the current cnt. A partial write in the same cycle as a tick lets the non-written bytes take the incremented value.
- Any write, or cnt_clr, forces div_cnt to 0 on that edge.
- wr_word >= NWORD: the write is ignored (no byte updated). Counting is unaffected.
- Wrap-around: all-ones plus tick becomes 0 with no stall.
- Halt handshake:
  - halt_ack <= halt_req & cnt_en, registered.
  - While halt_ack=1, neither cnt nor div_cnt changes on tick; writes and cnt_clr still apply.
  - Deasserting halt_req drops halt_ack on the next edge. Counting resumes the cycle after that, with div_cnt preserved.
- Compare:
  - cmp_match <= (cnt == cmp_val), using the registered cnt, so it has one cycle of latency.
  - cmp_int <= (cnt == cmp_val) & ~cmp_match.
  - A write that lands on cmp_val produces the match the cycle after the write.
- Reset asserted mid-count: all state returns to its reset value immediately (asynchronous). The first tick occurs no earlier than the second edge after release.

Optional Feature:
- Macro: TIMER_CNT_OVF_EN.
- Defined:
  - Adds output ovf_flag (1) and input ovf_clr (1).
  - ovf_flag is sticky and set the edge after a tick wraps all-ones to 0.
  - It is cleared by ovf_clr; set has priority over clear in the same cycle.
  - Reset value is 0. Writes and cnt_clr do not set it.
- Not defined: both ports are absent and no overflow logic is generated.

Test Plan:
- Reset and free-run:
  - Stimulus: CNT_W=64, reset, then cnt_en=1, div_en=0 for 10 cycles.
  - Required: cnt=0 during reset, then 1..10; halt_ack, cmp_match and cmp_int stay 0.
- Byte write during count:
  - Stimulus: cnt=0x0000_0000_0000_00FF, tick, and a write with wr_word=0, pstrb=4'b0010, wdt=0x0000_AB00, all in the same cycle.
  - Required: cnt=0x0000_0000_0000_AB00 (byte1 from the write, byte0 from the increment, upper bytes from cnt+1).
  - Stimulus: wr_word=1, pstrb=4'hF, wdt=0x1234_5678.
  - Required: cnt[63:32]=0x1234_5678.
- Prescaler:
  - Stimulus: div_en=1, div_val=3, cnt_en=1 for 12 cycles.
  - Required: cnt advances 0→3, one increment every 4 cycles.
  - Stimulus: lower div_val to 1 while div_cnt=2.
  - Required: tick occurs on the next cycle.
- Halt:
  - Stimulus: halt_req=1 at cnt=5.
  - Required: halt_ack=1 next edge; cnt frozen at 6 (the tick in the request cycle lands).
  - Stimulus: write wdt=0x20 to word 0 during halt.
  - Required: cnt=0x20.
  - Stimulus: release halt_req.
  - Required: halt_ack=0 next edge, then counting resumes at 0x21.
- Compare and wrap:
  - Stimulus: cmp_val=0x10, free-run from 0.
  - Required: cmp_match high the cycle after cnt=0x10; cmp_int is a single one-cycle pulse.
  - Stimulus: load all-ones, tick.
  - Required: cnt=0; with TIMER_CNT_OVF_EN, ovf_flag=1 until ovf_clr is pulsed.
- Clear versus write priority:
  - Stimulus: cnt_clr=1 with a write to word 0, pstrb=4'b0001, wdt=0xAA.
  - Required: cnt=0x...00AA (byte0 written, all other bytes cleared); div_cnt=0.
